// File: rtl/addr_bus_arbiter_if.sv
// Address-bus arbitration signals shared by the arbiter (master) and the
// bus drivers/listeners (slave).
interface addr_bus_arbiter_if #(
  parameter int NUM_REQ = 5
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] preempt;
  logic [2:0]         owner;
  logic               addr_valid;
  logic               busy;

  modport master (input req, output grant, owner, addr_valid, preempt, busy);
  modport slave  (output req, input grant, owner, addr_valid, preempt, busy);
endinterface

// File: rtl/addr_bus_arbiter.sv
// Round-robin owner arbiter for the 8-bit address bus with bounded hold time
// and dead turnaround cycles between owners. All outputs are registered.
module addr_bus_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  addr_bus_arbiter_if.master  bus
);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, preempt_q, preempt_d;
  logic [2:0]         owner_q, owner_d, last_q, last_d;
  logic [7:0]         hold_q, hold_d;
  logic [2:0]         turn_q, turn_d;
  logic               addr_valid_q, addr_valid_d, busy_q, busy_d;

  logic [2*NUM_REQ-1:0] req_rot;
  logic                 win_vld;
  logic [2:0]           win_idx;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 rel, pre, go_own;

  // Rotate so bit 0 is the index just after the last owner; lowest set bit wins.
  always_comb begin
    req_rot = {bus.req, bus.req} >> (int'(last_q) + 1);
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req_rot[i]) begin
        win_vld = 1'b1;
        win_idx = 3'((int'(last_q) + 1 + i >= NUM_REQ) ? int'(last_q) + 1 + i - NUM_REQ
                                                       : int'(last_q) + 1 + i);
      end
    end
  end

  assign owner_oh = ONE << owner_q;
  assign rel      = (bus.req & owner_oh) == '0;
  assign pre      = (MAX_HOLD != 0) && (hold_q == HOLD_LAST) && ((bus.req & ~owner_oh) != '0);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    preempt_d    = '0;
    owner_d      = owner_q;
    last_d       = last_q;
    hold_d       = hold_q;
    turn_d       = turn_q;
    addr_valid_d = addr_valid_q;
    busy_d       = busy_q;
    go_own       = 1'b0;
    case (state_q)
      IDLE: go_own = win_vld;
      OWN: begin
        hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        if (rel || pre) begin
          state_d      = TURN;
          grant_d      = '0;
          addr_valid_d = 1'b0;
          turn_d       = '0;
          // A simultaneous release wins over preemption: no pulse.
          preempt_d    = (pre && !rel) ? owner_oh : '0;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          if (win_vld) go_own = 1'b1;
          else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          turn_d = turn_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_own) begin
      state_d      = OWN;
      grant_d      = ONE << win_idx;
      owner_d      = win_idx;
      last_d       = win_idx;
      hold_d       = '0;
      addr_valid_d = 1'b1;
      busy_d       = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      preempt_q    <= '0;
      owner_q      <= '0;
      last_q       <= 3'(NUM_REQ - 1);
      hold_q       <= '0;
      turn_q       <= '0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      preempt_q    <= preempt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
      turn_q       <= turn_d;
      addr_valid_q <= addr_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.preempt    = preempt_q;
  assign bus.owner      = owner_q;
  assign bus.addr_valid = addr_valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/addr_bus_arbiter.md
Name: addr_bus_arbiter

Overview:
Arbiter and sequencer for the 8-bit address bus. The bus is shared by the address-bus drivers: M, XY, J, PC and INC. The block grants ownership to exactly one driver at a time using round-robin, with a bounded hold time. It inserts dead (turnaround) cycles between owners so two drivers never drive the bus together. It also gives the listeners (memory, 16-bit incrementer) a qualifier that says when the bus carries a valid address.

Parameters:
NUM_REQ, 5, number of requesters; index 0=M, 1=XY, 2=J, 3=PC, 4=INC; legal range 2..8
MAX_HOLD, 8, max consecutive OWN cycles before forced hand-off when another request is pending; 0 disables preemption; legal range 0..255
TURN_CYCLES, 1, dead cycles between any two grants; legal range 1..7

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-driver bus request; level, held until the driver is done
grant  output  NUM_REQ  one-hot or zero; the granted driver may enable its bus driver
owner  output  3  index of current or most recent owner
addr_valid  output  1  high when a grant is active; memory/16_INC qualify the address with it
preempt  output  NUM_REQ  one-cycle pulse to the owner whose grant is being revoked by MAX_HOLD
busy  output  1  high in OWN or TURN state

Behaviour:
- All outputs are registered. On reset: state=IDLE, grant=0, preempt=0, addr_valid=0, busy=0, owner=0, last_owner=NUM_REQ-1 (so the first arbitration favours M), hold_cnt=0, turn_cnt=0.
- Reset asserted mid-ownership: grant drops at the same edge. No turnaround is needed after reset.
- States are IDLE, OWN and TURN.
- IDLE:
  - grant=0.
  - If req!=0, arbitrate at this edge, go to OWN, assert grant[w], set owner=w, hold_cnt=0.
  - Latency: req seen at edge t gives grant high after edge t+1 (1 cycle).
- Arbitration (round-robin):
  - Search starts at index last_owner+1 and wraps modulo NUM_REQ.
  - The winner w is the first index with req set.
  - last_owner=w when the grant is issued.
- OWN:
  - grant[owner]=1, addr_valid=1, busy=1, and hold_cnt increments each cycle, saturating at 255.
  - Release: req[owner]=0 leads to TURN. grant drops after the next edge.
  - Preempt: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~onehot(owner))!=0 leads to TURN. preempt[owner] pulses high for exactly the cycle grant first reads 0.
  - If the owner keeps requesting with no competitor, the grant is held indefinitely and no preempt occurs.
  - Release and preempt in the same cycle: treated as release, no preempt pulse.
- TURN:
  - grant=0, addr_valid=0, busy=1, turn_cnt counts 0..TURN_CYCLES-1.
  - At the edge ending the last turn cycle: if req!=0, arbitrate and go to OWN; otherwise go to IDLE.
  - Requests that appear or drop during TURN are sampled only at that final edge.
- A preempted owner that still holds req goes back into rotation. It is searched last, because last_owner equals its index.
- Invariants (bench assertions):
  - $onehot0(grant) at all times.
  - Between deassertion of one grant and assertion of a different one there are at least TURN_CYCLES cycles with grant==0.
  - addr_valid == |grant.
  - preempt is nonzero only in the first TURN cycle.
  - grant never goes to an index whose req was 0 at the arbitration edge.
- Bits of req at index >= NUM_REQ are ignored. owner is zero-extended to 3 bits.

Test Plan:
- Reset then single request: req=5'b01000 (PC) at cycle 2 -> grant=5'b01000 from cycle 3, owner=3, addr_valid=1. Drop req at cycle 6 -> grant=0 from cycle 7, one TURN cycle, then IDLE with busy=0 from cycle 8.
- Round-robin fairness: req=5'b11111 held, MAX_HOLD=2 -> owners cycle 0,1,2,3,4,0. Each is granted 2 cycles, separated by 1 dead cycle. preempt pulses on each hand-off.
- Preemption limit: PC holds req, XY raises req at hold_cnt=3, MAX_HOLD=8 -> PC grant lasts exactly 8 cycles. preempt[3] pulses in cycle 9, grant[1] is asserted after TURN_CYCLES dead cycles.
- No competitor: M holds req for 40 cycles, MAX_HOLD=8 -> grant[0] continuous for all 40 cycles, preempt never asserts.
- Turnaround length: TURN_CYCLES=3, J releases while INC requests -> exactly 3 cycles with grant=0, then grant=5'b10000. Assertion checks zero overlap.
- Reset mid-ownership: reset pulsed in OWN with grant[2] high -> all outputs 0 after that edge. With req=5'b11111, the next grant goes to M (index 0).
